// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: FSM states, grant IDs, default widths.
// Both the top and the winner picker import this package.
package mem_arbiter_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int REG_WIDTH  = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [1:0] GID_NONE  = 2'd0;
    localparam logic [1:0] GID_HOST  = 2'd1;
    localparam logic [1:0] GID_EXEC  = 2'd2;
    localparam logic [1:0] GID_FETCH = 2'd3;

    // last_grant encoding: which of exec/fetch was served most recently
    localparam logic LG_EXEC  = 1'b0;
    localparam logic LG_FETCH = 1'b1;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection: host has absolute priority, exec/fetch
// alternate on a tie based on last_grant.
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
(
    input  logic       host_req,
    input  logic       exec_req,
    input  logic       fetch_req,
    input  logic       last_grant,
    output logic [1:0] winner
);

    always_comb begin
        winner = GID_NONE;
        if (host_req) begin
            winner = GID_HOST;
        end else if (exec_req && fetch_req) begin
            winner = (last_grant == LG_FETCH) ? GID_EXEC : GID_FETCH;
        end else if (exec_req) begin
            winner = GID_EXEC;
        end else if (fetch_req) begin
            winner = GID_FETCH;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-requester arbiter for a single-port synchronous memory.
// IDLE/RESP arbitrate, ACCESS drives the memory, RESP returns data and acks.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int DATA_W = REG_WIDTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    input  logic              exec_req,
    input  logic              exec_we,
    input  logic [ADDR_W-1:0] exec_addr,
    input  logic [DATA_W-1:0] exec_wdata,
    output logic              exec_ack,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        grant_id,
    output logic              busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    logic [1:0]        state;
    logic [1:0]        owner;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic              last_grant;

    logic              in_access;
    logic              in_resp;
    logic              host_m;
    logic              exec_m;
    logic              fetch_m;
    logic [1:0]        winner;
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] nxt_wdata;
    logic              nxt_we;

    assign in_access = (state == ST_ACCESS);
    assign in_resp   = (state == ST_RESP);

    // The requester being acked this cycle is not eligible again until next cycle
    assign host_m  = host_req  && !(in_resp && owner == GID_HOST);
    assign exec_m  = exec_req  && !(in_resp && owner == GID_EXEC);
    assign fetch_m = fetch_req && !(in_resp && owner == GID_FETCH);

    mem_arbiter_pick u_pick (
        .host_req   (host_m),
        .exec_req   (exec_m),
        .fetch_req  (fetch_m),
        .last_grant (last_grant),
        .winner     (winner)
    );

    always_comb begin
        nxt_addr  = '0;
        nxt_wdata = '0;
        nxt_we    = 1'b0;
        case (winner)
            GID_HOST: begin
                nxt_addr  = host_addr;
                nxt_wdata = host_wdata;
                nxt_we    = host_we;
            end
            GID_EXEC: begin
                nxt_addr  = exec_addr;
                nxt_wdata = exec_wdata;
                nxt_we    = exec_we;
            end
            GID_FETCH: begin
                nxt_addr  = fetch_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            owner      <= GID_NONE;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            last_grant <= LG_FETCH;
        end else begin
            case (state)
                ST_IDLE, ST_RESP: begin
                    owner     <= winner;
                    lat_addr  <= nxt_addr;
                    lat_wdata <= nxt_wdata;
                    lat_we    <= nxt_we;
                    if (winner == GID_NONE) begin
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_ACCESS;
                    end
                    if (winner == GID_EXEC) begin
                        last_grant <= LG_EXEC;
                    end else if (winner == GID_FETCH) begin
                        last_grant <= LG_FETCH;
                    end
                end
                ST_ACCESS: state <= ST_RESP;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = in_access || in_resp;
    assign grant_id  = busy ? owner : GID_NONE;
    assign host_ack  = in_resp && (owner == GID_HOST);
    assign exec_ack  = in_resp && (owner == GID_EXEC);
    assign fetch_ack = in_resp && (owner == GID_FETCH);
    assign rdata     = in_resp ? mem_dout : '0;

    // Gating with reset_n keeps a write from landing on the edge that resets us
    assign mem_we   = in_access && lat_we && reset_n;
    assign mem_addr = in_access ? lat_addr  : '0;
    assign mem_din  = in_access ? lat_wdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural registered memory and an
// ack scoreboard (expected owner, ack cycle and read data).
module tb_mem_arbiter;

    logic       clk;
    logic       reset_n;
    logic       preload;
    logic       host_req, host_we;
    logic [7:0] host_addr, host_wdata;
    logic       host_ack;
    logic       exec_req, exec_we;
    logic [7:0] exec_addr, exec_wdata;
    logic       exec_ack;
    logic       fetch_req;
    logic [7:0] fetch_addr;
    logic       fetch_ack;
    logic [7:0] rdata;
    logic [1:0] grant_id;
    logic       busy;
    logic       mem_we;
    logic [7:0] mem_addr, mem_din, mem_dout;

    logic [7:0] mem [0:255];
    int         cyc;
    int         n_chk;
    int         n_fail;

    // scoreboard entry: {ack_cycle[15:0], id[1:0], check_rdata, rdata[7:0]}
    logic [26:0] exp_q[$];

    mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .exec_req   (exec_req),
        .exec_we    (exec_we),
        .exec_addr  (exec_addr),
        .exec_wdata (exec_wdata),
        .exec_ack   (exec_ack),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ack  (fetch_ack),
        .rdata      (rdata),
        .grant_id   (grant_id),
        .busy       (busy),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    // ---------------- clock / reset / memory model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_din;
        end
        mem_dout <= mem[mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, 32'(grant_id), 32'(0));
        chk({tag, "_busy"},  32'(busy), 32'(0));
        chk({tag, "_we"},    32'(mem_we), 32'(0));
        chk({tag, "_addr"},  32'(mem_addr), 32'(0));
        chk({tag, "_din"},   32'(mem_din), 32'(0));
        chk({tag, "_rdata"}, 32'(rdata), 32'(0));
        chk({tag, "_acks"},  32'({host_ack, exec_ack, fetch_ack}), 32'(0));
    endtask

    task automatic push_exp(input int ack_cyc, input logic [1:0] id,
                            input logic chk_rd, input logic [7:0] rd);
        exp_q.push_back({16'(ack_cyc), id, chk_rd, rd});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    // Single request from IDLE: grant now, ACCESS next cycle, ack the cycle after
    task automatic do_access(input logic [1:0] id, input logic we, input logic [7:0] addr,
                             input logic [7:0] wdata, input logic chk_rd, input logic [7:0] rd);
        case (id)
            2'd1: begin host_req = 1; host_we = we; host_addr = addr; host_wdata = wdata; end
            2'd2: begin exec_req = 1; exec_we = we; exec_addr = addr; exec_wdata = wdata; end
            default: begin fetch_req = 1; fetch_addr = addr; end
        endcase
        push_exp(cyc + 2, id, chk_rd, rd);
        tick(1);
        chk("acc_busy",  32'(busy), 32'(1));
        chk("acc_grant", 32'(grant_id), 32'(id));
        chk("acc_we",    32'(mem_we), 32'(we && id != 2'd3));
        chk("acc_addr",  32'(mem_addr), 32'(addr));
        chk("acc_din",   32'(mem_din), 32'((id == 2'd3) ? 8'h00 : wdata));
        host_addr = ~addr; exec_addr = ~addr; fetch_addr = ~addr;
        host_wdata = ~wdata; exec_wdata = ~wdata;
        tick(1);
        chk("resp_we",   32'(mem_we), 32'(0));
        chk("resp_busy", 32'(busy), 32'(1));
        host_req = 0; exec_req = 0; fetch_req = 0;
        tick(1);
        chk_idle("post");
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [26:0] e;
        logic [1:0]  got;
        while (exp_q.size() > 0 && int'(exp_q[0][26:11]) < cyc) begin
            e = exp_q.pop_front();
            chk("ack_missed_cycle", 32'(cyc), 32'(e[26:11]));
        end
        if (host_ack || exec_ack || fetch_ack) begin
            got = host_ack ? 2'd1 : (exec_ack ? 2'd2 : 2'd3);
            chk("ack_onehot", 32'(host_ack) + 32'(exec_ack) + 32'(fetch_ack), 32'(1));
            if (exp_q.size() == 0) begin
                chk("ack_unexpected", 32'(got), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("ack_id",    32'(got), 32'(e[10:9]));
                chk("ack_cycle", 32'(cyc), 32'(e[26:11]));
                if (e[8]) chk("ack_rdata", 32'(rdata), 32'(e[7:0]));
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        n_chk = 0; n_fail = 0;
        reset_n = 0; preload = 1;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        exec_req = 0; exec_we = 0; exec_addr = 0; exec_wdata = 0;
        fetch_req = 0; fetch_addr = 0;
        tick(2);
        preload = 0;
        tick(2);
        chk_idle("reset");
        reset_n = 1;
        tick(1);

        // host write then host read back
        do_access(2'd1, 1'b1, 8'h05, 8'hA9, 1'b0, 8'h00);
        do_access(2'd1, 1'b0, 8'h05, 8'h00, 1'b1, 8'hA9);

        // exec and fetch both held from reset: exec, fetch, exec, fetch
        exec_req = 1; exec_we = 1; exec_addr = 8'h02; exec_wdata = 8'h04;
        fetch_req = 1; fetch_addr = 8'h10;
        do_reset();
        push_exp(cyc + 2, 2'd2, 1'b0, 8'h00);
        push_exp(cyc + 4, 2'd3, 1'b1, 8'h4A);
        push_exp(cyc + 6, 2'd2, 1'b0, 8'h00);
        push_exp(cyc + 8, 2'd3, 1'b1, 8'h4A);
        tick(1);
        chk("rr_grant1", 32'(grant_id), 32'(2));
        chk("rr_we1",    32'(mem_we), 32'(1));
        chk("rr_addr1",  32'(mem_addr), 32'(8'h02));
        tick(2);
        chk("rr_grant2", 32'(grant_id), 32'(3));
        chk("fetch_we0", 32'(mem_we), 32'(0));
        chk("rr_addr2",  32'(mem_addr), 32'(8'h10));
        tick(2);
        chk("rr_grant3", 32'(grant_id), 32'(2));
        tick(2);
        chk("rr_grant4", 32'(grant_id), 32'(3));
        exec_req = 0;
        tick(1);
        fetch_req = 0;
        tick(1);
        chk_idle("rr_end");
        chk("mem_02", 32'(mem[8'h02]), 32'(8'h04));
        chk("mem_10", 32'(mem[8'h10]), 32'(8'h4A));

        // all three in the same cycle from reset state
        do_reset();
        host_req = 1; host_we = 0; host_addr = 8'h05;
        exec_req = 1; exec_we = 0; exec_addr = 8'h02;
        fetch_req = 1; fetch_addr = 8'h10;
        push_exp(cyc + 2, 2'd1, 1'b1, 8'hA9);
        push_exp(cyc + 4, 2'd2, 1'b1, 8'h04);
        push_exp(cyc + 6, 2'd3, 1'b1, 8'h4A);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            if (k % 2 == 1) chk("all3_grant", 32'(grant_id), 32'(k / 2 + 1));
            if (k == 2) host_req = 0;
            if (k == 4) exec_req = 0;
            if (k == 6) fetch_req = 0;
        end
        tick(1);
        chk_idle("all3_end");

        // host arrives during exec ACCESS: no preemption, granted in exec RESP
        exec_req = 1; exec_we = 1; exec_addr = 8'h20; exec_wdata = 8'h33;
        push_exp(cyc + 2, 2'd2, 1'b0, 8'h00);
        tick(1);
        chk("np_grant_exec", 32'(grant_id), 32'(2));
        host_req = 1; host_we = 0; host_addr = 8'h20; host_wdata = 8'h00;
        push_exp(cyc + 3, 2'd1, 1'b1, 8'h33);
        tick(1);
        chk("np_still_exec", 32'(grant_id), 32'(2));
        exec_req = 0;
        tick(1);
        chk("np_grant_host", 32'(grant_id), 32'(1));
        chk("np_host_addr",  32'(mem_addr), 32'(8'h20));
        tick(1);
        host_req = 0;
        tick(1);
        chk_idle("np_end");

        // reset in the middle of a host write ACCESS
        do_access(2'd1, 1'b1, 8'h03, 8'h77, 1'b0, 8'h00);
        host_req = 1; host_we = 1; host_addr = 8'h03; host_wdata = 8'hEE;
        tick(1);
        chk("rst_acc_we", 32'(mem_we), 32'(1));
        reset_n = 0;
        #1;
        chk("rst_suppress_we", 32'(mem_we), 32'(0));
        tick(1);
        chk_idle("rst_mid");
        host_req = 0;
        tick(1);
        reset_n = 1;
        tick(1);
        chk("rst_mem_03", 32'(mem[8'h03]), 32'(8'h77));
        do_access(2'd1, 1'b0, 8'h03, 8'h00, 1'b1, 8'h77);

        tick(3);
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default `ADDR_WIDTH, address width.
- DATA_W, default `REG_WIDTH, data width.
REQ-002 Ports SHALL be as follows (one clock; reset is synchronous and active-low):
- clk  in  1  single clock, same as phi0 domain of mem.
- reset_n  in  1  synchronous active-low reset.
- host_req  in  1  loader/debug request.
- host_we  in  1  1=write, 0=read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_ack  out  1  one-cycle completion pulse.
- exec_req  in  1  decoder/execute data request.
- exec_we  in  1  1=write, 0=read.
- exec_addr  in  ADDR_W  execute address.
- exec_wdata  in  DATA_W  execute write data.
- exec_ack  out  1  one-cycle completion pulse.
- fetch_req  in  1  fetcher read request (read-only).
- fetch_addr  in  ADDR_W  fetch address.
- fetch_ack  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read data, valid in any ack cycle.
- grant_id  out  2  current owner: 0 none, 1 host, 2 exec, 3 fetch.
- busy  out  1  high in ACCESS or RESP.
- mem_we  out  1  to mem.we.
- mem_addr  out  ADDR_W  to mem.addr.
- mem_din  out  DATA_W  to mem.din.
- mem_dout  in  DATA_W  from mem.dout; registered, valid the cycle after mem samples addr.

Function
REQ-003 FSM SHALL have states IDLE, ACCESS, RESP; outputs SHALL be derived from registered state only, never combinationally from req inputs.
REQ-004 In IDLE, or in RESP, arbitration SHALL select a winner from the pending requests, and the FSM SHALL enter ACCESS next cycle. If nothing is pending it SHALL go to (or stay in) IDLE.
REQ-005 Priority SHALL be:
- host over everything.
- exec vs fetch round-robin via a last_grant bit: on a tie, the requester not served last wins.
- last_grant resets to fetch, so exec wins the first tie.
REQ-006 At grant, addr, we and wdata of the winner SHALL be latched. Requester inputs changing after grant SHALL be ignored until its ack.
REQ-007 In ACCESS, mem_addr and mem_din SHALL carry the latched values. mem_we SHALL equal the latched we, forced 0 for fetch.
REQ-008 In RESP:
- the owner's ack SHALL pulse for exactly one cycle.
- rdata SHALL equal mem_dout.
- mem_we SHALL be 0.
REQ-009 Latency SHALL be 2 cycles from grant (IDLE arbitration cycle N → ack in cycle N+2), identical for reads and writes.
REQ-010 During arbitration in RESP, the requester being acked SHALL be masked. Back-to-back service of different requesters SHALL give one access per 2 cycles.
REQ-011 A requester SHALL drop req in the cycle after its ack. A req held longer SHALL be treated as a new request from the cycle after ack.
REQ-012 A req dropped before ack SHALL NOT abort the access; the ack still pulses.
REQ-013 When all three requests arrive in the same cycle, the order SHALL be host, then exec, then fetch (from reset state).
REQ-014 A host request arriving while another access is in ACCESS or RESP SHALL wait; there SHALL be no preemption mid-access.
REQ-015 In IDLE:
- mem_we SHALL be 0, mem_addr 0, mem_din 0.
- grant_id SHALL be 0.
- busy SHALL be 0.
- rdata SHALL be 0.

Reset
REQ-016 While reset_n=0 at a clk edge:
- state SHALL go to IDLE.
- all acks SHALL be 0.
- mem_we SHALL be 0.
- grant_id SHALL be 0.
- last_grant SHALL be fetch.
- latched addr and data SHALL be 0.
REQ-017 A reset asserted in ACCESS or RESP SHALL abandon the access with no ack. A write in ACCESS at that edge SHALL be suppressed (mem_we=0 the following cycle).

Structure
REQ-018 State encodings (IDLE=0, ACCESS=1, RESP=2) and grant IDs (NONE=0, HOST=1, EXEC=2, FETCH=3) SHALL be `defines in PKG/pkg.v.
REQ-019 Winner selection SHALL be one combinational sub-module, mem_arb_pick (inputs: masked reqs, last_grant; output: winner ID).

Verification
REQ-020 Bench SHALL cover the following directed scenarios:
- Host write 0x05←0xA9, then host read 0x05 → host_ack at N+2 both times; rdata=0xA9 on the read ack.
- exec_req and fetch_req both held from reset, exec write 0x02←0x04, fetch read 0x10 → grant order exec, fetch, exec, fetch; acks 2 cycles apart.
- All three reqs in the same cycle → acks in order host (N+2), exec (N+4), fetch (N+6).
- Host req raised during an exec ACCESS → exec completes; host granted in exec's RESP cycle.
- reset_n=0 during a host write ACCESS to 0x03 (old 0x77) → no host_ack; mem[0x03] still 0x77; all outputs at reset values.
- Fetch with fetch_we tied... none (read-only): fetch read while exec_we=1 pending → mem_we=0 in fetch ACCESS; memory contents unchanged.
